updown_seq_checker: RTL and testbench

Receive-side monitor for the up/down triangle counter stream (0,1..MAX..1,0,1..). It samples the count bus on in_valid, locks onto the waveform direction and checks every transition against the expected triangle sequence. It reports direction, peak/valley events, sequence errors and completed periods, and sits downstream of the up/down counter in self-checking subsystems.

---
 rtl/updown_seq_checker.sv | 162 ++++++++++++++++
 tb/tb_updown_seq_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_checker.sv
// updown_seq_checker: receive-side monitor for the up/down triangle count stream.
// It locks onto the waveform direction, checks each accepted sample against the
// expected triangle sequence and reports turnarounds, errors and completed periods.
module updown_seq_checker #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned MAX    = 7,
  parameter int unsigned PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_count,
  output logic              locked,
  output logic              dir,
  output logic              peak,
  output logic              valley,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [PCNT_W-1:0] period_cnt
);

  // One extra bit so that prev+1 at the top of the bus never wraps.
  localparam int unsigned      EXT_W   = WIDTH + 1;
  localparam logic [EXT_W-1:0] MAX_X   = EXT_W'(MAX);
  localparam logic [EXT_W-1:0] ONE_X   = EXT_W'(1);
  localparam logic [7:0]       ERR_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic                locked_d, dir_d, peak_d, valley_d, err_d;
  logic [7:0]          err_cnt_d;
  logic [PCNT_W-1:0]   period_cnt_d;

  logic [EXT_W-1:0]    s_x, prev_x, prev_inc, prev_dec, exp_x;
  logic                exp_dir;
  logic                s_in_range, s_is_max, s_is_zero, prev_is_zero;

  // Widened sample/history views shared by the sync and track checks.
  always_comb begin
    s_x          = EXT_W'(in_count);
    prev_x       = EXT_W'(prev_q);
    prev_inc     = prev_x + ONE_X;
    prev_dec     = prev_x - ONE_X;
    s_in_range   = (s_x <= MAX_X);
    s_is_max     = (s_x == MAX_X);
    s_is_zero    = (s_x == '0);
    prev_is_zero = (prev_x == '0);
  end

  // Expected next value and direction while tracking, including turnarounds.
  always_comb begin
    exp_x   = prev_inc;
    exp_dir = 1'b0;
    if (!dir) begin
      if (prev_x == MAX_X) begin
        exp_x   = MAX_X - ONE_X;
        exp_dir = 1'b1;
      end else begin
        exp_x   = prev_inc;
        exp_dir = 1'b0;
      end
    end else begin
      if (prev_is_zero) begin
        exp_x   = ONE_X;
        exp_dir = 1'b0;
      end else begin
        exp_x   = prev_dec;
        exp_dir = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    dir_d        = dir;
    peak_d       = 1'b0;
    valley_d     = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt;
    period_cnt_d = period_cnt;

    if (in_valid) begin
      prev_d = in_count;
      case (state_q)
        IDLE: begin
          state_d = SYNC;
        end
        SYNC: begin
          if (s_in_range && (s_x == prev_inc)) begin
            dir_d    = 1'b0;
            state_d  = TRACK;
            peak_d   = s_is_max;
            valley_d = s_is_zero;
          end else if (s_in_range && !prev_is_zero && (s_x == prev_dec)) begin
            dir_d    = 1'b1;
            state_d  = TRACK;
            peak_d   = s_is_max;
            valley_d = s_is_zero;
          end else begin
            err_d = 1'b1;
          end
        end
        TRACK: begin
          if (s_x == exp_x) begin
            dir_d  = exp_dir;
            peak_d = s_is_max;
            if (s_is_zero) begin
              valley_d     = 1'b1;
              period_cnt_d = period_cnt + PCNT_W'(1);
            end
          end else begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (err_d && (err_cnt != ERR_SAT)) begin
        err_cnt_d = err_cnt + 8'd1;
      end
    end

    locked_d = (state_d == TRACK);
  end

  // State, history and registered outputs; async active-low reset clears all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      peak       <= 1'b0;
      valley     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      locked     <= locked_d;
      dir        <= dir_d;
      peak       <= peak_d;
      valley     <= valley_d;
      err        <= err_d;
      err_cnt    <= err_cnt_d;
      period_cnt <= period_cnt_d;
    end
  end

endmodule

// File: tb/tb_updown_seq_checker.sv
// tb_updown_seq_checker: scoreboard bench for updown_seq_checker with a
// behavioural triangle-sequence model, directed scenarios and random traffic.
module tb_updown_seq_checker;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned MAX    = 7;
  localparam int unsigned PCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_count = '0;
  logic              locked, dir, peak, valley, err;
  logic [7:0]        err_cnt;
  logic [PCNT_W-1:0] period_cnt;

  updown_seq_checker #(.WIDTH(WIDTH), .MAX(MAX), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .locked(locked), .dir(dir), .peak(peak), .valley(valley), .err(err),
    .err_cnt(err_cnt), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit dir;
    bit peak;
    bit valley;
    bit err;
    int err_cnt;
    int period_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: "have a previous sample", "locked", direction, counters.
  bit m_have_prev, m_locked, m_dir;
  int m_prev, m_errs, m_periods;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_have_prev = 1'b0; m_locked = 1'b0; m_dir = 1'b0;
    m_prev = 0; m_errs = 0; m_periods = 0;
  endtask

  // Triangle rules: a locked stream moves by one toward its direction and
  // bounces at 0 and MAX; an unlocked stream locks on any +-1 step within 0..MAX.
  task automatic model_step(input bit v, input int s, output exp_t e);
    int want;
    e.peak = 1'b0; e.valley = 1'b0; e.err = 1'b0;
    if (v) begin
      if (!m_have_prev) begin
        m_have_prev = 1'b1;
      end else if (!m_locked) begin
        if (s <= int'(MAX) && (s - m_prev == 1 || m_prev - s == 1)) begin
          m_locked = 1'b1;
          m_dir    = (s < m_prev);
          e.peak   = (s == int'(MAX));
          e.valley = (s == 0);
        end else begin
          e.err = 1'b1;
        end
      end else begin
        want = m_dir ? m_prev - 1 : m_prev + 1;
        if (want > int'(MAX) || want < 0) want = m_dir ? m_prev + 1 : m_prev - 1;
        if (s == want) begin
          m_dir  = (want < m_prev);
          e.peak = (s == int'(MAX));
          if (s == 0) begin
            e.valley  = 1'b1;
            m_periods = (m_periods + 1) % (1 << PCNT_W);
          end
        end else begin
          e.err    = 1'b1;
          m_locked = 1'b0;
        end
      end
      m_prev = s;
      if (e.err && m_errs < 255) m_errs++;
    end
    e.locked     = m_locked;
    e.dir        = m_dir;
    e.err_cnt    = m_errs;
    e.period_cnt = m_periods;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input bit v, input int s);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_count = v ? WIDTH'(s) : WIDTH'($urandom);
    model_step(v, s, e);
    sb_q.push_back(e);
  endtask

  // Let the last queued response be checked, then sit mid high phase.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_dir"}, int'(dir), 0);
    chk({tag, "_peak"}, int'(peak), 0);
    chk({tag, "_valley"}, int'(valley), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_period_cnt"}, int'(period_cnt), 0);
  endtask

  // Full triangle period starting at 0: 0,1..MAX..1,0 then a final 1.
  task automatic clean_period(input bit sparse);
    for (int i = 0; i <= int'(MAX); i++) begin
      drive(1'b1, i);
      if (sparse) drive(1'b0, 0);
    end
    for (int i = int'(MAX) - 1; i >= 0; i--) begin
      drive(1'b1, i);
      if (sparse) drive(1'b0, 0);
    end
    drive(1'b1, 1);
  endtask

  // Monitor: every clock the DUT presents one registered response per queued entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("locked", int'(locked), int'(e.locked));
        if (e.locked) chk("dir", int'(dir), int'(e.dir));
        chk("peak", int'(peak), int'(e.peak));
        chk("valley", int'(valley), int'(e.valley));
        chk("err", int'(err), int'(e.err));
        chk("err_cnt", int'(err_cnt), e.err_cnt);
        chk("period_cnt", int'(period_cnt), e.period_cnt);
      end
    end
  end

  initial begin : stimulus
    int src, sdir, wait_cyc;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Dense clean stream.
    clean_period(1'b0);
    settle();
    chk("dense_period_cnt", int'(period_cnt), 1);
    chk("dense_err_cnt", int'(err_cnt), 0);
    chk("dense_locked", int'(locked), 1);
    chk("dense_dir", int'(dir), 0);

    // Error injection 2,3,4,6 then relock on 5,4.
    drive(1, 2); drive(1, 3); drive(1, 4); drive(1, 6);
    settle();
    chk("inject_err", int'(err), 1);
    chk("inject_locked", int'(locked), 0);
    drive(1, 5); drive(1, 4);
    settle();
    chk("relock_locked", int'(locked), 1);
    chk("relock_dir", int'(dir), 1);
    chk("relock_err_cnt", int'(err_cnt), 1);

    // Mid-waveform start, descending.
    do_reset();
    drive(1, 5); drive(1, 4); drive(1, 3);
    settle();
    chk("mid_locked", int'(locked), 1);
    chk("mid_dir", int'(dir), 1);
    chk("mid_err_cnt", int'(err_cnt), 0);

    // No wrap from MAX to 0.
    do_reset();
    drive(1, 5); drive(1, 6); drive(1, 7); drive(1, 0);
    settle();
    chk("wrap_err", int'(err), 1);
    chk("wrap_valley", int'(valley), 0);
    chk("wrap_period_cnt", int'(period_cnt), 0);

    // Sparse clean stream with gaps.
    do_reset();
    clean_period(1'b1);
    settle();
    chk("sparse_period_cnt", int'(period_cnt), 1);

    // Async reset mid-stream with period_cnt=3, err_cnt=2.
    do_reset();
    drive(1, 5); drive(1, 5); drive(1, 5);
    for (int i = 4; i >= 0; i--) drive(1, i);
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= int'(MAX); i++) drive(1, i);
      for (int i = int'(MAX) - 1; i >= 0; i--) drive(1, i);
    end
    drive(1, 1);
    settle();
    chk("pre_rst_period_cnt", int'(period_cnt), 3);
    chk("pre_rst_err_cnt", int'(err_cnt), 2);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 3);
    settle();
    chk("post_rst_locked", int'(locked), 0);
    chk("post_rst_err", int'(err), 0);

    // Saturation of err_cnt.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1, 5);
    settle();
    chk("sat_err_cnt", int'(err_cnt), 255);

    // Randomised triangle traffic with gaps and corruption.
    do_reset();
    src  = int'($urandom_range(0, MAX));
    sdir = int'($urandom_range(0, 1));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 0);
      end else if ($urandom_range(0, 19) == 0) begin
        src = int'($urandom_range(0, MAX));
        drive(1'b1, src);
      end else begin
        if (sdir == 0 && src >= int'(MAX)) sdir = 1;
        else if (sdir == 1 && src <= 0) sdir = 0;
        src = (sdir == 0) ? src + 1 : src - 1;
        drive(1'b1, src);
      end
    end
    drive(1'b0, 0);

    // Drain the scoreboard under a cycle budget.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk("drain_queue_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
